interp_row_sched: RTL and testbench

- Sequencer for the 1/16-precision 8-tap MCM interpolation datapath (tap blocks t1..t8).
- Accepts one row of integer-position samples over a valid/ready stream.
- Builds the sliding 8-sample window and issues one window per output sample to the tap blocks' X inputs, together with the fraction select (1..15 picks Y1..Y15; 0 means integer position).
- Sits between the reference-sample fetch and the tap/adder tree.

---
 rtl/interp_pkg.sv | 16 +
 rtl/interp_tap_window.sv | 41 ++++
 rtl/interp_row_sched.sv | 198 +++++++++++++++++++
 tb/tb_interp_row_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared constants and state encoding for the interpolation row sequencer.
package interp_pkg;

    localparam int TAPS     = 8;
    localparam int SAMPLE_W = 32;
    localparam int FRAC_W   = 4;

    // Row sequencing phases: wait for start, prime the window, stream windows, report completion.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/interp_tap_window.sv
// TAPS-deep sample shift register feeding the tap blocks.
// Slice i of win_o is tap i; tap 0 holds the oldest sample and new samples
// enter at tap TAPS-1.
module interp_tap_window #(
    parameter int TAPS     = interp_pkg::TAPS,
    parameter int SAMPLE_W = interp_pkg::SAMPLE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     shift_en,
    input  logic [SAMPLE_W-1:0]      shift_in,
    output logic [TAPS*SAMPLE_W-1:0] win_o
);
    import interp_pkg::*;

    logic [TAPS*SAMPLE_W-1:0] win_q;
    logic [TAPS*SAMPLE_W-1:0] win_d;

    // Move every tap one place towards tap 0 and append the new sample on shift.
    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int i = 0; i < TAPS - 1; i++) begin
                win_d[i*SAMPLE_W +: SAMPLE_W] = win_q[(i+1)*SAMPLE_W +: SAMPLE_W];
            end
            win_d[(TAPS-1)*SAMPLE_W +: SAMPLE_W] = shift_in;
        end
    end

    // Window storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/interp_row_sched.sv
// Row sequencer for the 8-tap 1/16-precision interpolation datapath.
// Takes one row of integer-position samples, primes a TAPS-deep window with
// TAPS-1 samples, then issues one window per further sample to the tap blocks
// together with the row's fraction select.
//
// Handshake semantics (both streams): a beat transfers on a rising clk edge
// where valid & ready are both 1. A producer keeps valid and its payload
// stable until the transfer; ready may depend combinationally on the
// consumer's own state and, here, on win_ready (s_ready = !win_valid | win_ready
// in RUN), but valid never depends on ready.
module interp_row_sched #(
    parameter int SAMPLE_W = interp_pkg::SAMPLE_W,
    parameter int TAPS     = interp_pkg::TAPS,
    parameter int LEN_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [interp_pkg::FRAC_W-1:0] frac,
    input  logic [LEN_W-1:0]              row_len,
    output logic                          busy,
    output logic                          done,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_W-1:0]           s_data,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [TAPS*SAMPLE_W-1:0]      win_data,
    output logic [interp_pkg::FRAC_W-1:0] win_frac,
    output logic                          win_last
);
    import interp_pkg::*;

    localparam int                FILL_W    = $clog2(TAPS);
    // fill_cnt value on the edge that accepts the (TAPS-1)th priming sample.
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(TAPS - 2);

    state_e                   state_q,     state_d;
    logic [FRAC_W-1:0]        frac_q,      frac_d;
    logic [LEN_W-1:0]         out_cnt_q,   out_cnt_d;
    logic [FILL_W-1:0]        fill_cnt_q,  fill_cnt_d;
    logic                     win_valid_q, win_valid_d;
    logic [TAPS*SAMPLE_W-1:0] win_data_q,  win_data_d;
    logic [FRAC_W-1:0]        win_frac_q,  win_frac_d;
    logic                     win_last_q,  win_last_d;

    logic                     s_accept;
    logic                     win_hs;
    logic                     win_load;
    logic [TAPS*SAMPLE_W-1:0] tap_win;
    logic [TAPS*SAMPLE_W-1:0] next_win;

    assign s_accept = s_valid & s_ready;
    assign win_hs   = win_valid_q & win_ready;
    // In RUN every accepted sample completes a fresh window.
    assign win_load = (state_q == RUN) & s_accept;

    // The window as it will look after this cycle's shift; loaded into the
    // output register on the same edge so the window is valid one cycle later.
    assign next_win = {s_data, tap_win[TAPS*SAMPLE_W-1:SAMPLE_W]};

    interp_tap_window #(
        .TAPS     (TAPS),
        .SAMPLE_W (SAMPLE_W)
    ) u_tap_window (
        .clk      (clk),
        .rst      (rst),
        .shift_en (s_accept),
        .shift_in (s_data),
        .win_o    (tap_win)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a zero-length row goes straight to DONE without touching the stream.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (row_len != '0) ? FILL : DONE;
                end
            end
            FILL: begin
                if (s_accept && (fill_cnt_q == FILL_LAST)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (win_hs && win_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: stream ready gating plus the busy/done status.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        s_ready = 1'b0;
        case (state_q)
            IDLE: begin
                s_ready = 1'b0;
            end
            FILL: begin
                busy    = 1'b1;
                s_ready = 1'b1;
            end
            RUN: begin
                busy    = 1'b1;
                // Stop pulling samples once every window of the row is loaded,
                // and whenever the single output register cannot take a new one.
                s_ready = (out_cnt_q != '0) & (~win_valid_q | win_ready);
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Row parameters, counters and the window output register.
    always_comb begin
        frac_d      = frac_q;
        out_cnt_d   = out_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        win_frac_d  = win_frac_q;
        win_last_d  = win_last_q;

        // Row parameters are captured only from IDLE; start elsewhere is ignored.
        if ((state_q == IDLE) && start) begin
            frac_d     = frac;
            out_cnt_d  = row_len;
            fill_cnt_d = '0;
        end

        if ((state_q == FILL) && s_accept) begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
        end

        if (win_load) begin
            // A load always wins over a same-cycle handshake of the previous window.
            win_valid_d = 1'b1;
            win_data_d  = next_win;
            win_frac_d  = frac_q;
            win_last_d  = (out_cnt_q == LEN_W'(1));
            out_cnt_d   = out_cnt_q - LEN_W'(1);
        end else if (win_hs) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end
    end

    // Storage for row parameters, counters and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frac_q      <= '0;
            out_cnt_q   <= '0;
            fill_cnt_q  <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_frac_q  <= '0;
            win_last_q  <= 1'b0;
        end else begin
            frac_q      <= frac_d;
            out_cnt_q   <= out_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            win_frac_q  <= win_frac_d;
            win_last_q  <= win_last_d;
        end
    end

    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;
    assign win_frac  = win_frac_q;
    assign win_last  = win_last_q;

endmodule

// File: tb/tb_interp_row_sched.sv
// Self-checking bench for interp_row_sched. The reference model describes a row
// as a list of samples: window k is samples k..k+TAPS-1, the stream may accept
// at most row_len+TAPS-1 samples, and a window is pending whenever more
// windows have been completed than consumed.
module tb_interp_row_sched;

    localparam int SAMPLE_W = 32;
    localparam int TAPS     = 8;
    localparam int LEN_W    = 8;
    localparam int BUDGET   = 5000;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [3:0]               frac;
    logic [LEN_W-1:0]         row_len;
    logic                     busy;
    logic                     done;
    logic                     s_valid;
    logic                     s_ready;
    logic [SAMPLE_W-1:0]      s_data;
    logic                     win_valid;
    logic                     win_ready;
    logic [TAPS*SAMPLE_W-1:0] win_data;
    logic [3:0]               win_frac;
    logic                     win_last;

    int vectors     = 0;
    int miscompares = 0;

    // clock
    always #5 clk = ~clk;

    interp_row_sched #(
        .SAMPLE_W (SAMPLE_W),
        .TAPS     (TAPS),
        .LEN_W    (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frac      (frac),
        .row_len   (row_len),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_frac  (win_frac),
        .win_last  (win_last)
    );

    // Drive one row and check it cycle by cycle against the sample-list model.
    // base!=0 gives samples base, base+1, ...; base==0 gives random samples.
    task automatic run_row(input int f, input int len, input int pv, input int pr,
                           input int base, input int restart_at, input int stall_first,
                           input bit toggle_fill, output int fill_cycle);
        logic [SAMPLE_W-1:0]      samp[$];
        logic [TAPS*SAMPLE_W-1:0] exp_q[$];
        logic [TAPS*SAMPLE_W-1:0] w;
        int total, si, wi, cyc, loaded, stall_left;
        bit restarted, finished, m_wv, exp_sr, exp_done;

        total      = len + TAPS - 1;
        si         = 0;
        wi         = 0;
        cyc        = 0;
        stall_left = stall_first;
        restarted  = 0;
        finished   = 0;
        fill_cycle = -1;
        for (int i = 0; i < total; i++) begin
            samp.push_back((base != 0) ? SAMPLE_W'(base + i) : SAMPLE_W'($urandom));
        end
        for (int k = 0; k < len; k++) begin
            for (int t = 0; t < TAPS; t++) begin
                w[t*SAMPLE_W +: SAMPLE_W] = samp[k+t];
            end
            exp_q.push_back(w);
        end

        start   = 1'b1;
        frac    = 4'(f);
        row_len = LEN_W'(len);
        s_valid = 1'b0;
        @(posedge clk); #1;
        start   = 1'b0;
        frac    = 4'($urandom);
        row_len = LEN_W'($urandom);

        while (!finished && cyc < BUDGET) begin
            loaded = (si >= TAPS) ? (si - TAPS + 1) : 0;
            m_wv   = (loaded > wi);

            if (toggle_fill && si < TAPS - 1) s_valid = ((cyc % 2) == 0);
            else                              s_valid = ($urandom_range(1, 100) <= pv);
            s_data = (si < total) ? samp[si] : SAMPLE_W'($urandom);

            if (m_wv && wi == 0 && stall_left > 0) begin
                win_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                win_ready = ($urandom_range(1, 100) <= pr);
            end

            if (restart_at >= 0 && !restarted && si == restart_at) begin
                start     = 1'b1;
                frac      = 4'd2;
                row_len   = LEN_W'($urandom);
                restarted = 1;
            end else begin
                start = 1'b0;
            end

            @(negedge clk);
            exp_done = (wi == len);
            exp_sr   = (si < total) && !(m_wv && !win_ready);

            vectors++;
            if (s_ready !== exp_sr) begin
                miscompares++;
                $display("FAIL s_ready cyc=%0d: got %b expected %b", cyc, s_ready, exp_sr);
            end
            vectors++;
            if (win_valid !== m_wv) begin
                miscompares++;
                $display("FAIL win_valid cyc=%0d: got %b expected %b", cyc, win_valid, m_wv);
            end
            vectors++;
            if (done !== exp_done) begin
                miscompares++;
                $display("FAIL done cyc=%0d: got %b expected %b", cyc, done, exp_done);
            end
            vectors++;
            if (busy !== !exp_done) begin
                miscompares++;
                $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, !exp_done);
            end
            if (m_wv && exp_q.size() != 0) begin
                vectors++;
                if (win_data !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL win_data win=%0d: got %h expected %h", wi, win_data, exp_q[0]);
                end
                vectors++;
                if (win_frac !== 4'(f)) begin
                    miscompares++;
                    $display("FAIL win_frac win=%0d: got %0d expected %0d", wi, win_frac, f);
                end
                vectors++;
                if (win_last !== (wi == len - 1)) begin
                    miscompares++;
                    $display("FAIL win_last win=%0d: got %b expected %b", wi, win_last, (wi == len - 1));
                end
            end

            if (s_valid && s_ready && si < total) si++;
            if (si == TAPS - 1 && fill_cycle < 0) fill_cycle = cyc;
            if (win_valid && win_ready && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                wi++;
            end
            finished = exp_done;
            cyc++;
            @(posedge clk); #1;
        end

        start     = 1'b0;
        s_valid   = 1'b0;
        win_ready = 1'b0;
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL row_timeout: got %0d windows expected %0d", wi, len);
        end
        @(negedge clk);
        vectors++;
        if ({busy, done, s_ready, win_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_after_row: got %b expected 0000", {busy, done, s_ready, win_valid});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        frac      = 4'd0;
        row_len   = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        win_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, s_ready, win_valid, win_last} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, s_ready, win_valid, win_last});
        end
        vectors++;
        if (win_data !== '0) begin
            miscompares++;
            $display("FAIL reset_win_data: got %h expected 0", win_data);
        end
        vectors++;
        if (win_frac !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_win_frac: got %0d expected 0", win_frac);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int fc;
        run_row(5, 3, 100, 100, 1, -1, 0, 1'b0, fc);
    endtask

    task automatic test_zero_len();
        int pulses, first;
        bit sr_seen, wv_seen, busy_seen;
        pulses    = 0;
        first     = -1;
        sr_seen   = 0;
        wv_seen   = 0;
        busy_seen = 0;
        start     = 1'b1;
        frac      = 4'd9;
        row_len   = '0;
        s_valid   = 1'b1;
        s_data    = SAMPLE_W'($urandom);
        win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first < 0) first = c;
            end
            sr_seen   = sr_seen | s_ready;
            wv_seen   = wv_seen | win_valid;
            busy_seen = busy_seen | busy;
            @(posedge clk); #1;
        end
        s_valid   = 1'b0;
        win_ready = 1'b0;
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL zero_len_done_pulses: got %0d expected 1", pulses);
        end
        vectors++;
        if (first != 0) begin
            miscompares++;
            $display("FAIL zero_len_done_cycle: got %0d expected 0", first);
        end
        vectors++;
        if ({sr_seen, wv_seen, busy_seen} != 3'b000) begin
            miscompares++;
            $display("FAIL zero_len_activity: got %b expected 000", {sr_seen, wv_seen, busy_seen});
        end
    endtask

    task automatic test_stall();
        int fc;
        run_row(3, 2, 100, 100, 1, -1, 4, 1'b0, fc);
    endtask

    task automatic test_fill_toggle();
        int fc;
        run_row(11, 2, 100, 100, 1, -1, 0, 1'b1, fc);
        // Seven priming samples on alternate cycles: the last lands in cycle 12.
        vectors++;
        if (fc != 2 * (TAPS - 1) - 2) begin
            miscompares++;
            $display("FAIL fill_toggle_cycle: got %0d expected %0d", fc, 2 * (TAPS - 1) - 2);
        end
    endtask

    task automatic test_restart_ignored();
        int fc;
        run_row(5, 3, 100, 100, 1, 3, 0, 1'b0, fc);
        run_row(5, 4, 100, 100, 1, 9, 0, 1'b0, fc);
    endtask

    task automatic test_reset_mid_row();
        int n, done_seen, fc;
        n         = 0;
        done_seen = 0;
        start     = 1'b1;
        frac      = 4'd5;
        row_len   = LEN_W'(3);
        s_valid   = 1'b0;
        win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 40 && n < 9; c++) begin
            s_valid = 1'b1;
            s_data  = SAMPLE_W'(n + 1);
            @(negedge clk);
            if (s_ready) n++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        vectors++;
        if (n != 9) begin
            miscompares++;
            $display("FAIL reset_mid_feed: got %0d samples expected 9", n);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, s_ready, win_valid, win_last} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_mid_ctrl: got %b expected 00000", {busy, done, s_ready, win_valid, win_last});
        end
        vectors++;
        if (win_data !== '0 || win_frac !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_data: got %h/%0d expected 0/0", win_data, win_frac);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        @(posedge clk); #1;
        vectors++;
        if (done_seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got %0d active cycles expected 0", done_seen);
        end
        run_row(7, 3, 100, 100, 101, -1, 0, 1'b0, fc);
    endtask

    task automatic test_random_rows();
        int fc;
        run_row(0, 4, 80, 70, 0, -1, 0, 1'b0, fc);
        for (int r = 0; r < 6; r++) begin
            run_row($urandom_range(0, 15), $urandom_range(1, 12), $urandom_range(40, 100),
                    $urandom_range(30, 100), 0, -1, 0, 1'b0, fc);
        end
    endtask

    task automatic test_max_len();
        int fc;
        run_row($urandom_range(0, 15), 255, 90, 90, 0, -1, 0, 1'b0, fc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_stall();
        test_fill_toggle();
        test_restart_ignored();
        test_reset_mid_row();
        test_random_rows();
        test_max_len();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
